// File: rtl/matvec_pkg.sv
// ---------------------------------------------------------------------------
// matvec_pkg
// Shared types and constants for the streaming matrix-vector engine:
//   - state_t      : controller states (IDLE, LOAD, DRAIN, DONE)
//   - DEF_*        : default dimensions and widths
//   - min_acc_w()  : smallest accumulator width that cannot overflow
// ---------------------------------------------------------------------------
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_ROWS   = 8;
    localparam int DEF_COLS   = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;

    // Full product width plus one carry bit per doubling of summed terms.
    function automatic int min_acc_w(input int data_w, input int cols);
        return 2 * data_w + $clog2(cols);
    endfunction

endpackage

// File: rtl/matvec_mac_lane.sv
// ---------------------------------------------------------------------------
// matvec_mac_lane
// One row of the matrix-vector engine: a registered product (stage 1) and
// an accumulator that adds the registered product (stage 2).
// Build option: MATVEC_ENGINE_SIGNED_EN selects two's-complement operands
// and a sign-extended product; otherwise arithmetic is unsigned.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        zero the accumulator (wins over i_acc_en)
//   i_load       capture i_a*i_b into the product register
//   i_acc_en     add the product register into the accumulator
//   i_a, i_b     operands (DATA_W)
//   o_acc        accumulator value (ACC_W)
// ---------------------------------------------------------------------------
module matvec_mac_lane
    import matvec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_acc_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] r_prod;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_prod_ext;

`ifdef MATVEC_ENGINE_SIGNED_EN
    logic signed [PROD_W-1:0] w_a_ext;
    logic signed [PROD_W-1:0] w_b_ext;

    // Widen before multiplying so the low PROD_W bits are the exact product.
    assign w_a_ext    = PROD_W'($signed(i_a));
    assign w_b_ext    = PROD_W'($signed(i_b));
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'($signed(r_prod));
`else
    assign w_prod     = PROD_W'(i_a) * PROD_W'(i_b);
    assign w_prod_ext = ACC_W'(r_prod);
`endif

    // NOTE: product and accumulator are plain flops, not a memory, so they
    // take the asynchronous reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            if (i_load) begin
                r_prod <= w_prod;
            end
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/matvec_engine.sv
// ---------------------------------------------------------------------------
// matvec_engine
// Streaming matrix-vector multiply: C[i] = sum_j A[i][j]*B[j].
// One beat carries column j of A and element B[j]; ROWS MAC lanes run in
// parallel through a 2-stage multiply/accumulate pipeline.
// Build option: MATVEC_ENGINE_SIGNED_EN (two's-complement arithmetic,
// implemented in matvec_mac_lane); handshake and timing are unaffected.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear/abort, highest priority
//   start        begin an operation (honoured in IDLE and DONE)
//   in_valid     input beat valid
//   in_ready     engine accepts a beat (LOAD only)
//   in_b         vector element B[j]
//   in_a         column j of A, row i at [i*DATA_W +: DATA_W]
//   busy         operation in progress (LOAD, DRAIN)
//   done         one-cycle completion pulse
//   result       C[i] at [i*ACC_W +: ACC_W], held until next start/clr
// ---------------------------------------------------------------------------
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_b,
    input  logic [ROWS*DATA_W-1:0] in_a,
    output logic                   busy,
    output logic                   done,
    output logic [ROWS*ACC_W-1:0]  result
);

    if (ACC_W < min_acc_w(DATA_W, COLS)) begin : g_acc_w_check
        $error("matvec_engine: ACC_W too small for DATA_W and COLS");
    end

    localparam int CNT_W = $clog2(COLS + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_p_valid;
    logic             w_accept;
    logic             w_start_op;
    logic             w_last_beat;
    logic             w_clr_acc;

    // clr discards a beat presented in the same cycle.
    assign w_accept    = in_valid && in_ready && !clr;
    assign w_start_op  = start && !clr && (r_state == IDLE || r_state == DONE);
    assign w_last_beat = (r_beat_cnt == CNT_W'(COLS - 1));
    assign w_clr_acc   = clr || w_start_op;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    if (w_accept && w_last_beat) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? LOAD : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clr) begin
            w_state_nxt = IDLE;
        end
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Beat counter and stage-1 valid; the valid steers stage-2 accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_p_valid  <= 1'b0;
        end else if (clr) begin
            r_beat_cnt <= '0;
            r_p_valid  <= 1'b0;
        end else begin
            r_p_valid <= w_accept;
            if (w_start_op) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_lane
        matvec_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (w_clr_acc),
            .i_load   (w_accept),
            .i_acc_en (r_p_valid),
            .i_a      (in_a[g*DATA_W +: DATA_W]),
            .i_b      (in_b),
            .o_acc    (result[g*ACC_W +: ACC_W])
        );
    end

endmodule
